multicycle_control_fsm: RTL

- Control unit for the multi-cycle ARMv7 datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives the immediate-select control (o_Immediate_Src) and the datapath mux and write-enable controls.
- Owns the NZCV flags register and gates all architectural writes on ARM condition-code evaluation.

---
 rtl/arm_ctrl_pkg.sv | 133 +++++++++++++
 rtl/cond_check.sv | 40 ++++
 rtl/multicycle_control_fsm.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/arm_ctrl_pkg.sv
// Shared definitions for the multi-cycle ARMv7 control unit.
//   - state_t        : control FSM states
//   - OP_* / CMD_* / COND_* : instruction field encodings
//   - IMM_* / SRCB_* / RES_* / ALU_* : datapath control encodings
//   - sel_t          : bundle of datapath mux selects driven per state
//   - decode_cmd()   : DP cmd field -> ALU control and write/flag policy
package arm_ctrl_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    // Op field, instruction bits [27:26]
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    // DP cmd field, instruction bits [24:21]
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // Condition field, instruction bits [31:28]
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Immediate extension select
    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRCB_RM   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Result mux select
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // ALU operation
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    typedef struct packed {
        logic       adr_src;
        logic [1:0] result_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_control;
        logic [1:0] imm_src;
    } sel_t;

    typedef struct packed {
        logic [1:0] alu_control;
        logic       no_write;   // result never reaches the register file
        logic       is_cmp;     // flags updated regardless of S
        logic       nz_only;    // logical ops keep C and V
        logic       known;      // recognised command; others have no effect
    } cmd_dec_t;

    function automatic cmd_dec_t decode_cmd(input logic [3:0] cmd);
        cmd_dec_t d;
        d.alu_control = ALU_ADD;
        d.no_write    = 1'b1;
        d.is_cmp      = 1'b0;
        d.nz_only     = 1'b0;
        d.known       = 1'b0;
        unique case (cmd)
            CMD_ADD: begin
                d.alu_control = ALU_ADD;
                d.no_write    = 1'b0;
                d.known       = 1'b1;
            end
            CMD_SUB: begin
                d.alu_control = ALU_SUB;
                d.no_write    = 1'b0;
                d.known       = 1'b1;
            end
            CMD_AND: begin
                d.alu_control = ALU_AND;
                d.no_write    = 1'b0;
                d.nz_only     = 1'b1;
                d.known       = 1'b1;
            end
            CMD_ORR: begin
                d.alu_control = ALU_ORR;
                d.no_write    = 1'b0;
                d.nz_only     = 1'b1;
                d.known       = 1'b1;
            end
            CMD_CMP: begin
                d.alu_control = ALU_SUB;
                d.is_cmp      = 1'b1;
                d.known       = 1'b1;
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cond_check.sv
// ARM condition-code evaluation, purely combinational.
//   cond    : instruction condition field [31:28]
//   flags   : architectural NZCV (registered copy, not the live ALU flags)
//   cond_ex : 1 when the instruction is allowed to take architectural effect
module cond_check
    import arm_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;

    assign {n, z, c, v} = flags;

    always_comb begin
        cond_ex = 1'b0;
        unique case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = !z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = !c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = !n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = !v;
            COND_HI: cond_ex = c && !z;
            COND_LS: cond_ex = !c || z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = !z && (n == v);
            COND_LE: cond_ex = z || (n != v);
            COND_AL: cond_ex = 1'b1;
            COND_NV: cond_ex = 1'b0;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Control unit for the multi-cycle ARMv7 datapath.
// Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, drives datapath mux
// selects and write enables, and owns the NZCV flags register.
// Ports:
//   i_Clk, i_Reset          : clock, synchronous active-high reset
//   i_Cond/i_Op/i_Funct/i_Rd: instruction register fields (stable from DECODE)
//   i_ALU_Flags             : NZCV produced by the ALU this cycle
//   o_PC_Write, o_Mem_Write, o_IR_Write, o_Reg_Write : write enables
//   o_Adr_Src, o_Result_Src, o_ALU_Src_A, o_ALU_Src_B,
//   o_ALU_Control, o_Immediate_Src                   : datapath selects
//   o_Flags                 : architectural NZCV
//   o_State                 : current FSM state
module multicycle_control_fsm
    import arm_ctrl_pkg::*;
#(
    parameter int P_STATE_W = 4
) (
    input  logic                 i_Clk,
    input  logic                 i_Reset,
    input  logic [3:0]           i_Cond,
    input  logic [1:0]           i_Op,
    input  logic [5:0]           i_Funct,
    input  logic [3:0]           i_Rd,
    input  logic [3:0]           i_ALU_Flags,
    output logic                 o_PC_Write,
    output logic                 o_Adr_Src,
    output logic                 o_Mem_Write,
    output logic                 o_IR_Write,
    output logic                 o_Reg_Write,
    output logic [1:0]           o_Result_Src,
    output logic                 o_ALU_Src_A,
    output logic [1:0]           o_ALU_Src_B,
    output logic [1:0]           o_ALU_Control,
    output logic [1:0]           o_Immediate_Src,
    output logic [3:0]           o_Flags,
    output logic [P_STATE_W-1:0] o_State
);

    state_t   state;
    state_t   state_next;
    sel_t     sel_q;
    logic [3:0] flags;
    logic     cond_ex;
    cmd_dec_t dec;
    logic     rd_is_pc;
    logic     flag_update;

    // Mux selects as a pure function of state; evaluated on the next state so
    // they can be registered alongside it.
    function automatic sel_t select_for(input state_t s, input logic u_bit,
                                        input logic [1:0] cmd_alu);
        sel_t sel;
        sel = '0;
        unique case (s)
            FETCH: begin
                sel.alu_src_a   = 1'b1;
                sel.alu_src_b   = SRCB_FOUR;
                sel.alu_control = ALU_ADD;
                sel.result_src  = RES_ALU;
            end
            DECODE: begin
                sel.alu_src_a   = 1'b1;
                sel.alu_src_b   = SRCB_FOUR;
                sel.alu_control = ALU_ADD;
            end
            MEMADR: begin
                sel.alu_src_b   = SRCB_IMM;
                sel.imm_src     = IMM_MEM;
                sel.alu_control = u_bit ? ALU_ADD : ALU_SUB;
            end
            MEMRD:  sel.adr_src = 1'b1;
            MEMWR:  sel.adr_src = 1'b1;
            MEMWB:  sel.result_src = RES_RDATA;
            EXECR: begin
                sel.alu_src_b   = SRCB_RM;
                sel.alu_control = cmd_alu;
            end
            EXECI: begin
                sel.alu_src_b   = SRCB_IMM;
                sel.imm_src     = IMM_DP;
                sel.alu_control = cmd_alu;
            end
            ALUWB:  sel.result_src = RES_ALUOUT;
            BRANCH: begin
                sel.alu_src_a   = 1'b1;
                sel.alu_src_b   = SRCB_IMM;
                sel.imm_src     = IMM_BR;
                sel.alu_control = ALU_ADD;
                sel.result_src  = RES_ALU;
            end
            default: sel = '0;
        endcase
        return sel;
    endfunction

    cond_check u_cond_check (
        .cond    (i_Cond),
        .flags   (flags),
        .cond_ex (cond_ex)
    );

    assign dec      = decode_cmd(i_Funct[4:1]);
    assign rd_is_pc = (i_Rd == 4'd15);

    always_comb begin
        state_next = state;
        unique case (state)
            FETCH:  state_next = DECODE;
            DECODE: begin
                unique case (i_Op)
                    OP_MEM:  state_next = MEMADR;
                    OP_DP:   state_next = i_Funct[5] ? EXECI : EXECR;
                    OP_BR:   state_next = BRANCH;
                    OP_ILL:  state_next = FETCH;
                    default: state_next = FETCH;
                endcase
            end
            MEMADR: state_next = i_Funct[0] ? MEMRD : MEMWR;
            MEMRD:  state_next = MEMWB;
            MEMWB:  state_next = FETCH;
            MEMWR:  state_next = FETCH;
            EXECR:  state_next = ALUWB;
            EXECI:  state_next = ALUWB;
            ALUWB:  state_next = FETCH;
            BRANCH: state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    // Flags capture at the end of EXECR/EXECI; CMP updates regardless of S,
    // unrecognised commands never touch the flags.
    assign flag_update = ((state == EXECR) || (state == EXECI)) &&
                         (i_Op == OP_DP) && cond_ex && dec.known &&
                         (i_Funct[0] || dec.is_cmp);

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state <= FETCH;
            sel_q <= select_for(FETCH, 1'b0, ALU_ADD);
            flags <= '0;
        end else begin
            state <= state_next;
            sel_q <= select_for(state_next, i_Funct[3], dec.alu_control);
            if (flag_update) begin
                if (dec.nz_only) begin
                    flags <= {i_ALU_Flags[3:2], flags[1:0]};
                end else begin
                    flags <= i_ALU_Flags;
                end
            end
        end
    end

    // Write enables stay combinational so reset can suppress them in the
    // same cycle and condition failure is seen against the current flags.
    always_comb begin
        o_PC_Write  = 1'b0;
        o_Mem_Write = 1'b0;
        o_IR_Write  = 1'b0;
        o_Reg_Write = 1'b0;
        if (!i_Reset) begin
            unique case (state)
                FETCH: begin
                    o_PC_Write = 1'b1;
                    o_IR_Write = 1'b1;
                end
                MEMWR:  o_Mem_Write = cond_ex;
                MEMWB: begin
                    o_Reg_Write = cond_ex && !rd_is_pc;
                    o_PC_Write  = cond_ex && rd_is_pc;
                end
                ALUWB: begin
                    o_Reg_Write = cond_ex && !dec.no_write && !rd_is_pc;
                    o_PC_Write  = cond_ex && !dec.no_write && rd_is_pc;
                end
                BRANCH: o_PC_Write = cond_ex;
                default: ;
            endcase
        end
    end

    assign o_Adr_Src       = sel_q.adr_src;
    assign o_Result_Src    = sel_q.result_src;
    assign o_ALU_Src_A     = sel_q.alu_src_a;
    assign o_ALU_Src_B     = sel_q.alu_src_b;
    assign o_ALU_Control   = sel_q.alu_control;
    assign o_Immediate_Src = sel_q.imm_src;
    assign o_Flags         = flags;
    assign o_State         = P_STATE_W'(state);

endmodule
